// File: rtl/denom_share_arbiter.sv
// Round-robin arbiter sharing one softsign denominator unit among NREQ
// requesters. Ports: CLOCK/reset, req/req_x in, ack/result/err out,
// busy/grant_id status, unit_start/unit_x/unit_done/unit_result to the unit.
module denom_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     CLOCK,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_x,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         result,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     unit_start,
  output logic [WIDTH-1:0]         unit_x,
  input  logic                     unit_done,
  input  logic [WIDTH-1:0]         unit_result
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] PTR_RST = GW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [GW-1:0]    ptr_q;
  logic [GW-1:0]    grant_q;
  logic [CW-1:0]    cnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             busy_q;
  logic             start_q;
  logic [WIDTH-1:0] unit_x_q;

  logic             found_d;
  logic [GW-1:0]    sel_d;
  logic [GW-1:0]    cand;
  logic [WIDTH-1:0] sel_x_d;

  // Search ptr+1 .. ptr (wrapping); the last granted requester
  // is checked last so every other pending requester goes first.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(ptr_q) + i) % NREQ);
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        sel_d   = cand;
      end
    end
    sel_x_d = req_x[sel_d*WIDTH +: WIDTH];
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_RST;
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      unit_x_q <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (found_d) begin
            grant_q  <= sel_d;
            unit_x_q <= sel_x_d;
            cnt_q    <= '0;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // done has priority over an expiring timeout
          if (unit_done) begin
            result_q <= unit_result;
            err_q    <= 1'b0;
            ack_q    <= NREQ'(1) << grant_q;
            state_q  <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
            ack_q    <= NREQ'(1) << grant_q;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          ptr_q   <= grant_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign unit_start = start_q;
  assign unit_x     = unit_x_q;

endmodule

// File: tb/tb_denom_share_arbiter.sv
// Directed bench for denom_share_arbiter with a behavioural unit model
// (configurable done latency, result = operand + 1).
module tb_denom_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic             CLOCK = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0]  ack;
  logic [W-1:0]     result;
  logic             err;
  logic             busy;
  logic [1:0]       grant_id;
  logic             unit_start;
  logic [W-1:0]     unit_x;
  logic             unit_done;
  logic [W-1:0]     unit_result;

  int vectors = 0;
  int miscompares = 0;

  int       lat = 3;
  logic     stray = 1'b0;
  logic     model_done = 1'b0;
  logic [W-1:0] model_res = '0;
  logic [W-1:0] mx = '0;
  bit       act = 1'b0;
  int       k = 0;

  assign unit_done   = model_done | stray;
  assign unit_result = model_res;

  always #5 CLOCK = ~CLOCK;

  denom_share_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .TIMEOUT(15)
  ) dut (
    .CLOCK(CLOCK), .reset(reset),
    .req(req), .req_x(req_x),
    .ack(ack), .result(result), .err(err),
    .busy(busy), .grant_id(grant_id),
    .unit_start(unit_start), .unit_x(unit_x),
    .unit_done(unit_done), .unit_result(unit_result)
  );

  // Unit model: done is seen in cycle start+lat; lat=0 never answers.
  always @(negedge CLOCK) begin
    if (reset) begin
      act = 1'b0;
    end else if (unit_start) begin
      act = 1'b1;
      k = 0;
      mx = unit_x;
    end else if (act) begin
      k++;
    end
    if (act && lat != 0 && k == lat) begin
      model_done = 1'b1;
      model_res = mx + 1;
      act = 1'b0;
    end else begin
      model_done = 1'b0;
    end
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick;
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req = '0;
    req_x = '0;
    tick;
    tick;
    vectors++;
    if ({ack, result, err, busy, grant_id, unit_start, unit_x} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b res=%h err=%b busy=%b gid=%0d st=%b ux=%h want all 0",
               ack, result, err, busy, grant_id, unit_start, unit_x);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    lat = 3;
    req_x[0 +: W] = 32'h5;
    req = 4'b0001;
    tick;
    vectors++;
    if (unit_start !== 1'b1 || unit_x !== 32'h5 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_issue: start=%b ux=%h busy=%b want 1 5 1",
               unit_start, unit_x, busy);
    end
    tick;
    vectors++;
    if (unit_start !== 1'b0 || unit_x !== 32'h5) begin
      miscompares++;
      $display("FAIL single_start_pulse: start=%b ux=%h want 0 5", unit_start, unit_x);
    end
    tick;
    tick;
    vectors++;
    if (ack !== 4'b0) begin
      miscompares++;
      $display("FAIL single_early_ack: ack=%b want 0000", ack);
    end
    tick;
    vectors++;
    if (ack !== 4'b0001 || result !== 32'h6 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b res=%h err=%b want 0001 6 0", ack, result, err);
    end
    req = '0;
    tick;
    vectors++;
    if (ack !== 4'b0 || busy !== 1'b0 || result !== 32'h6) begin
      miscompares++;
      $display("FAIL single_idle: ack=%b busy=%b res=%h want 0000 0 6", ack, busy, result);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    bit ok;
    do_reset;
    lat = 3;
    for (int i = 0; i < NREQ; i++) req_x[i*W +: W] = 32'h100 + i;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(40, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rr_timeout: no ack for grant %0d want ack", n);
      end
      vectors++;
      if (ack !== (4'b1 << order[n]) || grant_id !== 2'(order[n]) ||
          result !== 32'h101 + order[n]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: ack=%b gid=%0d res=%h want ack for %0d res %h",
                 n, ack, grant_id, result, order[n], 32'h101 + order[n]);
      end
      if (n == 4) req = '0;
      tick;
      vectors++;
      if (ack !== 4'b0) begin
        miscompares++;
        $display("FAIL rr_ack_width%0d: ack=%b want 0000", n, ack);
      end
    end
  endtask

  task automatic test_priority_wrap;
    bit ok;
    lat = 3;
    req = 4'b0100;
    wait_ack(40, ok);
    vectors++;
    if (!ok || ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_first: ok=%b ack=%b want 0100", ok, ack);
    end
    req = 4'b0101;
    wait_ack(40, ok);
    vectors++;
    if (!ok || ack !== 4'b0001 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_second: ok=%b ack=%b gid=%0d want 0001 0", ok, ack, grant_id);
    end
    req = 4'b0100;
    wait_ack(40, ok);
    vectors++;
    if (!ok || ack !== 4'b0100 || result !== 32'h103) begin
      miscompares++;
      $display("FAIL wrap_third: ok=%b ack=%b res=%h want 0100 103", ok, ack, result);
    end
    req = '0;
    tick;
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset;
    lat = 0;
    req_x[0 +: W] = 32'h7;
    req = 4'b0001;
    tick;
    repeat (15) tick;
    vectors++;
    if (ack !== 4'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early: ack=%b busy=%b want 0000 1", ack, busy);
    end
    tick;
    vectors++;
    if (ack !== 4'b0001 || result !== 32'h0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_ack: ack=%b res=%h err=%b want 0001 0 1", ack, result, err);
    end
    req = '0;
    tick;
    vectors++;
    if (ack !== 4'b0 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_err_hold: ack=%b err=%b busy=%b want 0000 1 0", ack, err, busy);
    end
    lat = 3;
    req_x[0 +: W] = 32'h9;
    req = 4'b0001;
    wait_ack(40, ok);
    vectors++;
    if (!ok || err !== 1'b0 || result !== 32'hA) begin
      miscompares++;
      $display("FAIL to_clear: ok=%b err=%b res=%h want 1 0 a", ok, err, result);
    end
    req = '0;
    tick;
  endtask

  task automatic test_collision;
    lat = 15;
    req_x[0 +: W] = 32'h20;
    req = 4'b0001;
    tick;
    vectors++;
    if (unit_start !== 1'b1 || unit_x !== 32'h20) begin
      miscompares++;
      $display("FAIL col_issue: start=%b ux=%h want 1 20", unit_start, unit_x);
    end
    repeat (15) tick;
    vectors++;
    if (ack !== 4'b0) begin
      miscompares++;
      $display("FAIL col_early: ack=%b want 0000", ack);
    end
    tick;
    vectors++;
    if (ack !== 4'b0001 || err !== 1'b0 || result !== 32'h21) begin
      miscompares++;
      $display("FAIL col_ack: ack=%b err=%b res=%h want 0001 0 21", ack, err, result);
    end
    req = '0;
    tick;
  endtask

  task automatic test_stray_done;
    stray = 1'b1;
    tick;
    stray = 1'b0;
    vectors++;
    if (ack !== 4'b0 || busy !== 1'b0 || unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_now: ack=%b busy=%b st=%b want 0000 0 0", ack, busy, unit_start);
    end
    tick;
    vectors++;
    if (ack !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 ||
        result !== 32'h21 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_after: ack=%b busy=%b gid=%0d res=%h err=%b want 0000 0 0 21 0",
               ack, busy, grant_id, result, err);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    lat = 3;
    req_x[1*W +: W] = 32'h31;
    req = 4'b0010;
    wait_ack(40, ok);
    vectors++;
    if (!ok || ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_prep: ok=%b ack=%b want 0010", ok, ack);
    end
    req = '0;
    tick;
    req = 4'b1111;
    tick;
    vectors++;
    if (grant_id !== 2'd2 || unit_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pregrant: gid=%0d st=%b want 2 1", grant_id, unit_start);
    end
    tick;
    reset = 1'b1;
    req = '0;
    tick;
    vectors++;
    if (busy !== 1'b0 || ack !== 4'b0 || grant_id !== 2'd0 ||
        unit_x !== 32'h0 || unit_start !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: busy=%b ack=%b gid=%0d ux=%h st=%b want 0 0000 0 0 0",
               busy, ack, grant_id, unit_x, unit_start);
    end
    reset = 1'b0;
    req = 4'b1111;
    wait_ack(40, ok);
    vectors++;
    if (!ok || ack !== 4'b0001 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_regrant: ok=%b ack=%b gid=%0d want 0001 0", ok, ack, grant_id);
    end
    req = '0;
    tick;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_x = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_priority_wrap;
    test_timeout;
    test_collision;
    test_stray_done;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, want completion");
    $fatal(1);
  end

endmodule
